// File: rtl/exc_irq_ctrl.sv
// Exception / interrupt controller: latches pending IRQs, arbitrates between
// undefined-instruction traps and masked IRQ channels, and hands one cause at a
// time to the pipeline through an IDLE -> SIGNAL -> HANDLER handshake.
module exc_irq_ctrl #(
   parameter int N_IRQ = 4,
   parameter int ESW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] ExtIRQ,
   input  logic [N_IRQ-1:0] IrqMask,
   input  logic             NotAnInstr,
   input  logic             ExcAck,
   input  logic             ERet,
   output logic             Exc,
   output logic [ESW-1:0]   EStatus,
   output logic [N_IRQ-1:0] ExtIAck,
   output logic             Busy,
   output logic             DblFault
);

   typedef enum logic [1:0] {
      IDLE,
      SIGNAL,
      HANDLER
   } state_t;

   state_t             state_q, state_d;
   logic [N_IRQ-1:0]   pend_q, pend_d;
   logic [N_IRQ-1:0]   sel_q, sel_d;       // one-hot channel under service, 0 for undefined instr
   logic [ESW-1:0]     estatus_q, estatus_d;
   logic [N_IRQ-1:0]   iack_q, iack_d;
   logic               dbl_q, dbl_d;

   logic [N_IRQ-1:0]   pend_eff;
   logic [N_IRQ-1:0]   req_vec;
   logic [N_IRQ-1:0]   pick_sel;
   logic [2:0]         pick_idx;

   // Pending view including this cycle's requests, and lowest-index enabled pick.
   always_comb begin
      pend_eff = pend_q | ExtIRQ;
      req_vec  = pend_eff & IrqMask;
      pick_sel = '0;
      pick_idx = '0;
      // Scan downwards so the lowest set index is the one left standing.
      for (int k = N_IRQ - 1; k >= 0; k--) begin
         if (req_vec[k]) begin
            pick_sel    = '0;
            pick_sel[k] = 1'b1;
            pick_idx    = 3'(k);
         end
      end
   end

   // Next-state and registered-output logic of the service handshake.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      pend_d    = pend_eff;
      sel_d     = sel_q;
      estatus_d = estatus_q;
      iack_d    = '0;
      dbl_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (NotAnInstr) begin
               state_d   = SIGNAL;
               estatus_d = ESW'(4'h2);
               sel_d     = '0;
            end else if (|req_vec) begin
               state_d   = SIGNAL;
               estatus_d = ESW'({1'b1, pick_idx});
               sel_d     = pick_sel;
            end
         end
         SIGNAL: begin
            // A second fault freezes the handshake; the acknowledge is not taken.
            if (NotAnInstr) begin
               dbl_d = 1'b1;
            end else if (ExcAck) begin
               state_d = HANDLER;
               iack_d  = sel_q;
               pend_d  = pend_eff & ~sel_q;
            end
         end
         HANDLER: begin
            if (NotAnInstr) begin
               dbl_d = 1'b1;
            end else if (ERet) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so all flops sample together.
         state_q   <= IDLE;
         pend_q    <= '0;
         sel_q     <= '0;
         estatus_q <= '0;
         iack_q    <= '0;
         dbl_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         sel_q     <= sel_d;
         estatus_q <= estatus_d;
         iack_q    <= iack_d;
         dbl_q     <= dbl_d;
      end
   end

   assign Exc      = (state_q == SIGNAL);
   assign Busy     = (state_q == HANDLER);
   assign EStatus  = estatus_q;
   assign ExtIAck  = iack_q;
   assign DblFault = dbl_q;

endmodule
